data_mem_arbiter: RTL

//   Two-requester arbiter and sequencer in front of the single-port data memory (registered read, 1-cycle latency).

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/data_mem_arbiter_if.sv | 16 +
 rtl/data_mem_arbiter_sat_counter.sv | 16 +
 rtl/data_mem_arbiter.sv | 81 ++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared widths and types for the two-port data memory arbiter.
// The optional statistics counters are enabled with MEM_ARB_STATS_EN.
package mem_arb_pkg;
   localparam int WORD     = 16;
   localparam int ADDRESSL = 10;
   localparam int CNT_W    = 16;
   localparam int NUM_PORTS = 2;

   typedef logic port_id_t;

   typedef struct packed {
      logic     valid;
      port_id_t port;
   } rd_pend_t;
endpackage

// File: rtl/data_mem_arbiter_if.sv
// One requester port of the data memory arbiter: valid/ready request plus tagged read response.
interface data_mem_arbiter_if #(
   parameter int WORD     = mem_arb_pkg::WORD,
   parameter int ADDRESSL = mem_arb_pkg::ADDRESSL
) ();
   logic                req;
   logic                we;
   logic [ADDRESSL-1:0] addr;
   logic [WORD-1:0]     wdata;
   logic                ready;
   logic                rvalid;
   logic [WORD-1:0]     rdata;

   modport master (output req, we, addr, wdata, input ready, rvalid, rdata);
   modport slave  (input req, we, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/data_mem_arbiter_sat_counter.sv
// Saturating event counter with synchronous clear (clear wins over increment).
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  cnt <= '0;
      else if (clr)                cnt <= '0;
      else if (inc && (cnt != '1)) cnt <= cnt + CNT_W'(1);
   end
endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter/sequencer for two requesters in front of a registered-read data memory.
// MEM_ARB_STATS_EN adds per-port grant, conflict counters and a stats_clr input.
module data_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WORD     = mem_arb_pkg::WORD,
   parameter int ADDRESSL = mem_arb_pkg::ADDRESSL
`ifdef MEM_ARB_STATS_EN
   , parameter int CNT_W  = mem_arb_pkg::CNT_W
`endif
) (
   input  logic                clk,
   input  logic                rst_n,
   data_mem_arbiter_if.slave   p0,
   data_mem_arbiter_if.slave   p1,
   output logic [ADDRESSL-1:0] mem_address,
   output logic [WORD-1:0]     mem_writeData,
   output logic                mem_memWrite,
   output logic                mem_memRead,
   input  logic [WORD-1:0]     mem_readData
`ifdef MEM_ARB_STATS_EN
   , input  logic              stats_clr
   , output logic [CNT_W-1:0]  p0_gnt_cnt
   , output logic [CNT_W-1:0]  p1_gnt_cnt
   , output logic [CNT_W-1:0]  conflict_cnt
`endif
);
   logic [NUM_PORTS-1:0]               req, we, gnt, rvalid;
   logic [NUM_PORTS-1:0][ADDRESSL-1:0] addr;
   logic [NUM_PORTS-1:0][WORD-1:0]     wdata;
   port_id_t                           last_gnt, win;
   rd_pend_t                           rd_pend;
   logic                               any;

   assign req   = {p1.req,   p0.req};
   assign we    = {p1.we,    p0.we};
   assign addr  = {p1.addr,  p0.addr};
   assign wdata = {p1.wdata, p0.wdata};

   // Under contention the port that did not win last time goes first.
   assign gnt[0] = req[0] && (!req[1] || last_gnt);
   assign gnt[1] = req[1] && (!req[0] || !last_gnt);
   assign any    = |gnt;
   assign win    = port_id_t'(gnt[1]);

   assign mem_address   = any ? addr[win]  : '0;
   assign mem_writeData = any ? wdata[win] : '0;
   assign mem_memWrite  = rst_n && any &&  we[win];
   assign mem_memRead   = rst_n && any && !we[win];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt <= 1'b1;
         rd_pend  <= '0;
      end else begin
         if (any) last_gnt <= win;
         rd_pend.valid <= any && !we[win];
         rd_pend.port  <= (any && !we[win]) ? win : 1'b0;
      end
   end

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_rsp
      assign rvalid[i] = rd_pend.valid && (rd_pend.port == port_id_t'(i));
   end

   assign p0.ready  = gnt[0];
   assign p1.ready  = gnt[1];
   assign p0.rvalid = rvalid[0];
   assign p1.rvalid = rvalid[1];
   assign p0.rdata  = mem_readData;
   assign p1.rdata  = mem_readData;

`ifdef MEM_ARB_STATS_EN
   sat_counter #(.CNT_W(CNT_W)) u_p0_cnt (
      .clk(clk), .rst_n(rst_n), .inc(gnt[0]), .clr(stats_clr), .cnt(p0_gnt_cnt));
   sat_counter #(.CNT_W(CNT_W)) u_p1_cnt (
      .clk(clk), .rst_n(rst_n), .inc(gnt[1]), .clr(stats_clr), .cnt(p1_gnt_cnt));
   sat_counter #(.CNT_W(CNT_W)) u_conf_cnt (
      .clk(clk), .rst_n(rst_n), .inc(req[0] && req[1]), .clr(stats_clr), .cnt(conflict_cnt));
`endif
endmodule
